stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Front-end controller for the stopwatch. Drives the 2-bit count-control bus into the time counter.
//  Each of three raw push-buttons (start/stop, clear, lap) is synchronised, debounced and edge-detected.
//  A Moore FSM (IDLE/COUNT/PAUSE/LAP) decodes the button presses into cnt_ctrl.
//  It also drives a display-freeze flag for the segment-display path.
// PARAMETERS
//  DEB_CNT  20  consecutive clock edges a synced button level must differ from its debounced level
//               before being accepted (1_000_000 = 20 ms @ 50 MHz in silicon; 20 for simulation)
//  DEB_W    20  width of each debounce counter; must satisfy 2**DEB_W > DEB_CNT
// PORTS
//  clk          in   1  system clock, 50 MHz, rising edge
//  rst          in   1  asynchronous, active-high reset
//  btn_ss       in   1  raw start/stop button, active-high, asynchronous to clk, bouncy
//  btn_clr      in   1  raw clear button, active-high, asynchronous, bouncy
//  btn_lap      in   1  raw lap button, active-high, asynchronous, bouncy
//  cnt_ctrl     out  2  count control: 2'b00 IDLE (clear), 2'b01 COUNT, 2'b10 PAUSE (hold); 2'b11 never driven
//  disp_freeze  out  1  1 = display path holds its last latched digits while the counter runs on
//  running      out  1  1 while the time base advances (COUNT or LAP)
// BEHAVIOUR
//  Reset: while rst=1 all flops clear.
//   - synchronisers, debounced levels, delayed levels and debounce counters = 0
//   - state = IDLE, so cnt_ctrl=2'b00, disp_freeze=0, running=0
//   - rst mid-operation aborts any count in progress at once; no press pulse is produced by the reset itself
//  Per-button front end (three identical copies):
//   - two-flop synchroniser: s1 <= btn; s2 <= s1
//   - debounce counter: if s2 == deb, counter <= 0. Otherwise counter increments.
//     When counter == DEB_CNT-1 and s2 != deb, deb <= s2 and counter <= 0.
//     Net effect: deb follows s2 only after DEB_CNT consecutive mismatching edges.
//     Any shorter pulse or glitch is discarded and produces no event.
//   - deb_d <= deb; press = deb & ~deb_d (one-cycle pulse, combinational). Releases generate nothing.
//   - a button held through reset deassertion is accepted as a press DEB_CNT+3 edges later
//  Latency: the first edge that samples a new stable level is edge 1.
//   - s2 is valid after edge 2; deb flips at edge 2+DEB_CNT
//   - the state register and cnt_ctrl update at edge 3+DEB_CNT
//  FSM (Moore; outputs decoded from the state register only):
//   IDLE : ss -> COUNT; clr, lap ignored.                                          cnt_ctrl=00 frz=0 run=0
//   COUNT: ss -> PAUSE; lap -> LAP; clr ignored (must pause first).                cnt_ctrl=01 frz=0 run=1
//   LAP  : ss -> PAUSE; lap -> COUNT (release freeze); clr ignored.                cnt_ctrl=01 frz=1 run=1
//   PAUSE: ss -> COUNT; clr -> IDLE; lap ignored.                                  cnt_ctrl=10 frz=0 run=0
//   - simultaneous pulses: ss has priority over clr and lap, and clr over lap
//     e.g. PAUSE with ss+clr in the same cycle -> COUNT
//   - holding a button produces exactly one press; a new press requires a debounced release (deb back to 0)
//   - unreachable state encodings recover to IDLE on the next edge
//  Outputs are registered or decoded directly from flops: no combinational path from btn_* to any output.
// TESTING
//  T1 reset: assert rst mid-COUNT -> immediately cnt_ctrl=00, disp_freeze=0, running=0; remain IDLE after release.
//  T2 latency: btn_ss rises and holds from IDLE -> cnt_ctrl goes 00->01 exactly DEB_CNT+3 edges after first sampling edge
//     (edge 23 with DEB_CNT=20); no change earlier.
//  T3 bounce: btn_ss toggles every 5 cycles for 60 cycles, then holds high -> exactly one transition, IDLE->COUNT,
//     DEB_CNT+3 edges after the final rising edge; 19-cycle high glitch -> no transition.
//  T4 sequence: ss, lap, lap, ss, clr -> cnt_ctrl 01,01,01,10,00; disp_freeze 0,1,0,0,0; running 1,1,1,0,0.
//  T5 illegal/priority: clr in COUNT -> stays 01; lap in PAUSE -> stays 10; ss+clr together in PAUSE -> COUNT (01).
//  T6 held button: btn_ss held 500 cycles from IDLE -> single IDLE->COUNT; release then press -> COUNT->PAUSE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end (sync, debounce, edge detect) for the
// start/stop, clear and lap buttons, plus a Moore FSM that turns the press
// pulses into the count-control bus, the display-freeze flag and the run flag.
module stopwatch_ctrl #(
  parameter int DEB_CNT = 20,   // edges a new level must persist before it is accepted
  parameter int DEB_W   = 20    // debounce counter width, 2**DEB_W > DEB_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [1:0] cnt_ctrl,
  output logic       disp_freeze,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic [2:0]       btn_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       deb_d;
  logic [2:0]       press;
  logic [DEB_W-1:0] deb_cnt [3];

  state_t state;
  state_t state_nxt;

  assign btn_raw = {btn_lap, btn_clr, btn_ss};

  // Two-flop synchroniser for the raw buttons and one-cycle delay of the debounced level.
  // NOTE: the raw buttons are asynchronous; sync1 may go metastable, so nothing but sync2 reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving a true two-stage chain.
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  // Debounce: accept the synced level only after DEB_CNT consecutive mismatching edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      // NOTE: the counter array is three small registers, not a RAM, so resetting every entry is cheap and required.
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of each debounced level is a one-cycle press; releases produce nothing.
  assign press = deb & ~deb_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start/stop outranks clear, clear outranks lap.
  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no path can infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (press[BTN_SS]) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (press[BTN_SS])       state_nxt = ST_PAUSE;
        else if (press[BTN_LAP]) state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (press[BTN_SS])       state_nxt = ST_PAUSE;
        else if (press[BTN_LAP]) state_nxt = ST_COUNT;
      end
      ST_PAUSE: begin
        if (press[BTN_SS])       state_nxt = ST_COUNT;
        else if (press[BTN_CLR]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only; 2'b11 is never driven on cnt_ctrl.
  always_comb begin
    cnt_ctrl    = 2'b00;
    disp_freeze = 1'b0;
    running     = 1'b0;
    case (state)
      ST_COUNT: begin
        cnt_ctrl = 2'b01;
        running  = 1'b1;
      end
      ST_LAP: begin
        cnt_ctrl    = 2'b01;
        disp_freeze = 1'b1;
        running     = 1'b1;
      end
      ST_PAUSE: begin
        cnt_ctrl = 2'b10;
      end
      default: begin
        cnt_ctrl = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus randomized button traffic,
// all outputs compared every cycle against a behavioural model of the controller.
module tb_stopwatch_ctrl;

  localparam int DC = 20;
  localparam int SS  = 0;
  localparam int CLR = 1;
  localparam int LAP = 2;

  // Model state codes (independent of the design's encoding).
  localparam int M_IDLE  = 0;
  localparam int M_COUNT = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [1:0] cnt_ctrl;
  logic       disp_freeze;
  logic       running;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  stopwatch_ctrl #(.DEB_CNT(DC), .DEB_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_ss      (btn[SS]),
    .btn_clr     (btn[CLR]),
    .btn_lap     (btn[LAP]),
    .cnt_ctrl    (cnt_ctrl),
    .disp_freeze (disp_freeze),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit raw_q  [3][$];   // button samples still in flight to the synchronised level
  bit s2_win [3][$];   // last DC synchronised samples
  bit m_deb      [3];
  bit m_deb_prev [3];
  int m_state;
  bit pr_ss, pr_clr, pr_lap, s2v, all_diff;

  function automatic int fsm_next(int s, bit ss, bit clr, bit lap);
    case (s)
      M_IDLE:  return ss ? M_COUNT : M_IDLE;
      M_COUNT: return ss ? M_PAUSE : (lap ? M_LAP : M_COUNT);
      M_LAP:   return ss ? M_PAUSE : (lap ? M_COUNT : M_LAP);
      M_PAUSE: return ss ? M_COUNT : (clr ? M_IDLE : M_PAUSE);
      default: return M_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] exp_ctrl(int s);
    case (s)
      M_COUNT, M_LAP: return 2'b01;
      M_PAUSE:        return 2'b10;
      default:        return 2'b00;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = M_IDLE;
      for (int b = 0; b < 3; b++) begin
        raw_q[b]      = {1'b0, 1'b0};
        s2_win[b]     = {};
        m_deb[b]      = 1'b0;
        m_deb_prev[b] = 1'b0;
      end
    end else begin
      // A press is a debounced level that rose at the previous edge.
      pr_ss   = m_deb[SS]  && !m_deb_prev[SS];
      pr_clr  = m_deb[CLR] && !m_deb_prev[CLR];
      pr_lap  = m_deb[LAP] && !m_deb_prev[LAP];
      m_state = fsm_next(m_state, pr_ss, pr_clr, pr_lap);
      for (int b = 0; b < 3; b++) begin
        // Synchronised level seen at this edge is the button as sampled two edges ago.
        s2v = raw_q[b].pop_front();
        raw_q[b].push_back(btn[b]);
        m_deb_prev[b] = m_deb[b];
        s2_win[b].push_back(s2v);
        if (s2_win[b].size() > DC) void'(s2_win[b].pop_front());
        all_diff = (s2_win[b].size() == DC);
        for (int k = 0; k < s2_win[b].size(); k++) begin
          if (s2_win[b][k] == m_deb[b]) all_diff = 1'b0;
        end
        if (all_diff) m_deb[b] = !m_deb[b];
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cnt_ctrl",    cnt_ctrl,    exp_ctrl(m_state));
      check("model_disp_freeze", disp_freeze, m_state == M_LAP);
      check("model_running",     running,     (m_state == M_COUNT) || (m_state == M_LAP));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m);
    @(negedge clk);
    btn = m;
    settle(DC + 8);
    btn = '0;
    settle(DC + 8);
  endtask

  task automatic check_out(input string tag, input logic [1:0] c, input logic f, input logic r);
    check({tag, "_ctrl"},    cnt_ctrl,    c);
    check({tag, "_freeze"},  disp_freeze, f);
    check({tag, "_running"}, running,     r);
  endtask

  // Count edges from now until cnt_ctrl becomes want; returns 0 if it never does.
  task automatic edges_until(input logic [1:0] want, output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (cnt_ctrl == want) begin
        n = i;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    btn = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    settle(3);
    chk_en = 1'b1;
    check_out("reset", 2'b00, 1'b0, 1'b0);
    #2 rst = 1'b0;

    // Latency of a clean press from IDLE.
    @(negedge clk);
    btn[SS] = 1'b1;
    edges_until(2'b01, lat);
    check("t2_latency", lat, DC + 3);
    @(negedge clk);
    btn[SS] = 1'b0;
    settle(DC + 8);

    // Bouncing start/stop back to IDLE first.
    press(3'b001);
    press(3'b010);
    check_out("t2_back_idle", 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      btn[SS] = (k % 2 == 0);
      settle(5);
    end
    check("t3_bounce_ignored", cnt_ctrl, 2'b00);
    btn[SS] = 1'b1;
    edges_until(2'b01, lat);
    check("t3_latency", lat, DC + 3);
    @(negedge clk);
    btn[SS] = 1'b0;
    settle(DC + 8);
    btn[SS] = 1'b1;
    settle(DC - 1);
    btn[SS] = 1'b0;
    settle(40);
    check_out("t3_glitch", 2'b01, 1'b0, 1'b1);
    press(3'b001);
    press(3'b010);
    check_out("t3_idle", 2'b00, 1'b0, 1'b0);

    // Normal sequence ss, lap, lap, ss, clr.
    press(3'b001); check_out("t4_ss",   2'b01, 1'b0, 1'b1);
    press(3'b100); check_out("t4_lap",  2'b01, 1'b1, 1'b1);
    press(3'b100); check_out("t4_lap2", 2'b01, 1'b0, 1'b1);
    press(3'b001); check_out("t4_ss2",  2'b10, 1'b0, 1'b0);
    press(3'b010); check_out("t4_clr",  2'b00, 1'b0, 1'b0);

    // Ignored presses and priority.
    press(3'b001); check_out("t5_count",   2'b01, 1'b0, 1'b1);
    press(3'b010); check_out("t5_clr_cnt", 2'b01, 1'b0, 1'b1);
    press(3'b001); check_out("t5_pause",   2'b10, 1'b0, 1'b0);
    press(3'b100); check_out("t5_lap_pau", 2'b10, 1'b0, 1'b0);
    press(3'b011); check_out("t5_ss_clr",  2'b01, 1'b0, 1'b1);
    press(3'b110); check_out("t5_clr_lap", 2'b01, 1'b1, 1'b1);
    press(3'b001);
    press(3'b010);
    check_out("t5_idle", 2'b00, 1'b0, 1'b0);

    // Held button gives one press only.
    @(negedge clk);
    btn[SS] = 1'b1;
    settle(500);
    check_out("t6_held", 2'b01, 1'b0, 1'b1);
    btn[SS] = 1'b0;
    settle(DC + 8);
    press(3'b001);
    check_out("t6_repress", 2'b10, 1'b0, 1'b0);
    press(3'b010);

    // Reset in the middle of counting.
    press(3'b001);
    check_out("t1_counting", 2'b01, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_out("t1_rst_now", 2'b00, 1'b0, 1'b0);
    settle(3);
    #2 rst = 1'b0;
    settle(50);
    check_out("t1_after", 2'b00, 1'b0, 1'b0);

    // Randomized button traffic with occasional resets.
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b1;
        settle(2);
        #2 rst = 1'b0;
      end
      if ($urandom_range(0, 2) != 0) btn = 3'(1 << $urandom_range(0, 2));
      else                           btn = 3'($urandom_range(0, 7));
      settle($urandom_range(1, 45));
    end
    btn = '0;
    settle(DC + 8);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
